imm_gen_stage: RTL and testbench
================================

// Module: imm_gen_stage
// PURPOSE
//  Registered producer side of the ALU operand-2 path. Accepts 32-bit RV32I instruction words from fetch.
//  Extracts and sign-extends the immediate for the instruction format.
//  Generates the matching alu2_sel code: ALU2_RS=1'b0, ALU2_IMM=1'b1.
//  Sits between fetch and the operand muxes. Buffers up to 2 decoded results behind a valid/ready handshake so execute stalls do not drop instructions.
// PARAMETERS
//  REG_LEN   32   data/immediate width (from rysy_pkg.vh); only 32 supported
//  DEPTH     2    result buffer entries; fixed at 2 (skid buffer)
// PORTS
//  clk        in   1        rising-edge clock
//  rst_n      in   1        asynchronous active-low reset
//  flush      in   1        synchronous: discard all buffered results
//  in_valid   in   1        instr is valid
//  in_ready   out  1        block can accept instr this cycle
//  instr      in   32       RV32I instruction word
//  out_valid  out  1        imm/alu2_sel/illegal are valid
//  out_ready  in   1        consumer takes the result this cycle
//  imm        out  REG_LEN  decoded immediate
//  alu2_sel   out  1        operand-2 select for ALU mux
//  illegal    out  1        opcode not recognised
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - count=0, out_valid=0, in_ready=1, imm=0, alu2_sel=ALU2_RS, illegal=0.
//   - Release is synchronised by the first clk edge.
//  Handshake:
//   - Accept when in_valid & in_ready. Deliver when out_valid & out_ready.
//   - out_valid must not depend combinationally on out_ready.
//   - in_ready = (count<2) and is a registered function of count; it does not look at out_ready.
//   - Output fields stay stable while out_valid & !out_ready.
//  Latency:
//   - An instruction accepted at edge N appears on the outputs after edge N (visible in cycle N+1) when the buffer is empty.
//   - Otherwise it is queued behind the older entry, strictly in order.
//  Buffer states (count): EMPTY(0), ONE(1), FULL(2).
//   - Accept only: count+1.
//   - Deliver only: count-1; the second entry moves to the head.
//   - Both in ONE: count stays 1; the new entry becomes the head on the same edge.
//   - Both in FULL: impossible, because in_ready=0.
//  Decode (opcode = instr[6:0]; all signs taken from instr[31]):
//   - I-type (0010011, 0000011, 1100111): imm = sext(instr[31:20]); sel=IMM.
//     OP-IMM with funct3 001/101: imm = zext(instr[24:20]).
//   - S-type (0100011): imm = sext({instr[31:25], instr[11:7]}); sel=IMM.
//   - B-type (1100011): imm = sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}); sel=RS.
//   - U-type (0110111, 0010111): imm = {instr[31:12], 12'b0}; sel=IMM.
//   - J-type (1101111): imm = sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}); sel=IMM.
//   - R-type (0110011): imm = 0; sel=RS.
//   - Any other opcode: imm = 0; sel=RS; illegal=1. It is still buffered and delivered in order.
//  Flush:
//   - flush=1 at an edge sets count=0 and out_valid=0.
//   - Any simultaneous accept is discarded; flush has priority over accept and deliver.
//   - in_ready=1 in the cycle after the flush.
//  Reset mid-operation: all entries are lost immediately; outputs return to reset values asynchronously.
//  Entries are written only on accept. Output registers hold their last value when count=0 (no X leakage).
// TESTING
//  1. Reset: rst_n=0 mid-cycle with count=2 -> out_valid=0, in_ready=1, imm=0 immediately (no clock needed).
//  2. addi x1,x0,-1 (0xFFF00093), out_ready=1 -> next cycle out_valid=1, imm=0xFFFFFFFF, alu2_sel=1, illegal=0.
//  3. Per-format vectors:
//     - sw x2,8(x1) (0x0020A423) -> imm=8, sel=1.
//     - beq x0,x0,-4 (0xFE000EE3) -> imm=0xFFFFFFFC, sel=0.
//     - lui x5,0x12345 (0x123452B7) -> imm=0x12345000, sel=1.
//     - jal x0,+2048 (0x0010006F) -> imm=0x00000800, sel=1.
//  4. Backpressure: out_ready=0; push 3 instrs -> in_ready=0 after the 2nd accept.
//     Raise out_ready -> the 3 instrs are delivered in order, none lost or duplicated.
//  5. Flush: count=2 with in_valid=1 and flush=1 at the same edge -> next cycle out_valid=0, in_ready=1, incoming instr dropped.
//  6. Opcode 0x7F, then slli x1,x1,5 (0x00509093) -> illegal=1, imm=0, sel=0; then imm=5, sel=1, illegal=0.

Source files
------------

// File: rtl/imm_gen_stage.sv
// -----------------------------------------------------------------------------
// imm_gen_stage
//   Registered producer of the ALU operand-2 path. Decodes RV32I instruction
//   words into a sign/zero-extended immediate plus the operand-2 select, and
//   buffers up to two decoded results behind a valid/ready handshake so that
//   execute stalls never drop an instruction.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   flush      in   synchronous discard of every buffered result
//   in_valid   in   instr is valid
//   in_ready   out  block can accept instr this cycle (registered, count<2)
//   instr      in   RV32I instruction word
//   out_valid  out  imm/alu2_sel/illegal are valid
//   out_ready  in   consumer takes the head result this cycle
//   imm        out  decoded immediate
//   alu2_sel   out  operand-2 select (0 = register, 1 = immediate)
//   illegal    out  opcode not recognised
// -----------------------------------------------------------------------------
module imm_gen_stage #(
  parameter int unsigned REG_LEN = 32,
  parameter int unsigned DEPTH   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [REG_LEN-1:0] imm,
  output logic               alu2_sel,
  output logic               illegal
);

  localparam logic ALU2_RS  = 1'b0;
  localparam logic ALU2_IMM = 1'b1;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // Occupancy of the two-entry skid buffer.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_e;

  // One decoded result as held in the buffer.
  typedef struct packed {
    logic [REG_LEN-1:0] imm;
    logic               sel;
    logic               ill;
  } entry_t;

  state_e state_q, state_d;
  entry_t head_q, head_d;
  entry_t tail_q, tail_d;
  logic   out_valid_q, out_valid_d;
  logic   in_ready_q, in_ready_d;

  entry_t      dec;
  logic [31:0] imm32;
  logic        accept;
  logic        deliver;

  // Immediate extraction and operand-2 select for the incoming word.
  always_comb begin
    imm32   = 32'd0;
    dec     = '0;
    dec.sel = ALU2_RS;
    dec.ill = 1'b0;
    case (instr[6:0])
      OPC_OP_IMM: begin
        // Shift-immediates carry an unsigned 5-bit shamt, not a signed imm.
        if (instr[14:12] == 3'b001 || instr[14:12] == 3'b101) begin
          imm32 = {27'd0, instr[24:20]};
        end else begin
          imm32 = {{20{instr[31]}}, instr[31:20]};
        end
        dec.sel = ALU2_IMM;
      end
      OPC_LOAD, OPC_JALR: begin
        imm32   = {{20{instr[31]}}, instr[31:20]};
        dec.sel = ALU2_IMM;
      end
      OPC_STORE: begin
        imm32   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        dec.sel = ALU2_IMM;
      end
      OPC_BRANCH: begin
        // Branches compare two registers; the offset goes to the PC adder.
        imm32   = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                   instr[11:8], 1'b0};
        dec.sel = ALU2_RS;
      end
      OPC_LUI, OPC_AUIPC: begin
        imm32   = {instr[31:12], 12'd0};
        dec.sel = ALU2_IMM;
      end
      OPC_JAL: begin
        imm32   = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                   instr[30:21], 1'b0};
        dec.sel = ALU2_IMM;
      end
      OPC_OP: begin
        imm32   = 32'd0;
        dec.sel = ALU2_RS;
      end
      default: begin
        imm32   = 32'd0;
        dec.sel = ALU2_RS;
        dec.ill = 1'b1;
      end
    endcase
    dec.imm = REG_LEN'(imm32);
  end

  assign accept  = in_valid & in_ready_q;
  assign deliver = out_valid_q & out_ready;

  // Buffer next-state: head is always the oldest entry and drives the outputs.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (flush) begin
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (accept) begin
            head_d  = dec;
            state_d = S_ONE;
          end
        end
        S_ONE: begin
          case ({accept, deliver})
            2'b11: head_d = dec;
            2'b10: begin
              tail_d  = dec;
              state_d = S_FULL;
            end
            2'b01:   state_d = S_EMPTY;
            default: state_d = S_ONE;
          endcase
        end
        S_FULL: begin
          // accept cannot happen here since in_ready is low.
          if (deliver) begin
            head_d  = tail_q;
            state_d = S_ONE;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
    out_valid_d = (state_d != S_EMPTY);
    in_ready_d  = (32'(state_d) < DEPTH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_EMPTY;
      head_q      <= '0;
      tail_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign out_valid = out_valid_q;
  assign in_ready  = in_ready_q;
  assign imm       = head_q.imm;
  assign alu2_sel  = head_q.sel;
  assign illegal   = head_q.ill;

endmodule

// File: tb/tb_imm_gen_stage.sv
module tb_imm_gen_stage;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] imm;
  logic        alu2_sel;
  logic        illegal;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] got_q[$];

  imm_gen_stage #(.REG_LEN(32), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .imm(imm), .alu2_sel(alu2_sel), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every delivered immediate, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) got_q.push_back(imm);
  end

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] imm;
    logic        sel;
    logic        ill;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] w);
    in_valid = 1'b1;
    instr    = w;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{"addi_m1",   32'hFFF00093, 32'hFFFFFFFF, 1'b1, 1'b0};
    vecs[1]  = '{"sw_8",      32'h0020A423, 32'h00000008, 1'b1, 1'b0};
    vecs[2]  = '{"beq_m4",    32'hFE000EE3, 32'hFFFFFFFC, 1'b0, 1'b0};
    vecs[3]  = '{"lui",       32'h123452B7, 32'h12345000, 1'b1, 1'b0};
    vecs[4]  = '{"jal_2048",  32'h0010006F, 32'h00000800, 1'b1, 1'b0};
    vecs[5]  = '{"illegal7f", 32'h0000007F, 32'h00000000, 1'b0, 1'b1};
    vecs[6]  = '{"slli_5",    32'h00509093, 32'h00000005, 1'b1, 1'b0};
    vecs[7]  = '{"srai_5",    32'h4050D093, 32'h00000005, 1'b1, 1'b0};
    vecs[8]  = '{"add",       32'h002081B3, 32'h00000000, 1'b0, 1'b0};
    vecs[9]  = '{"auipc",     32'hFFFFF117, 32'hFFFFF000, 1'b1, 1'b0};
    vecs[10] = '{"jalr_min",  32'h80000067, 32'hFFFFF800, 1'b1, 1'b0};
    vecs[11] = '{"lw_m4",     32'hFFC0A083, 32'hFFFFFFFC, 1'b1, 1'b0};
    vecs[12] = '{"sw_m4",     32'hFE20AE23, 32'hFFFFFFFC, 1'b1, 1'b0};
    vecs[13] = '{"jal_m4",    32'hFFDFF06F, 32'hFFFFFFFC, 1'b1, 1'b0};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; instr = 32'd0;
    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_imm",       imm,                32'd0);
    chk("rst_sel",       {31'd0, alu2_sel},  32'd0);
    chk("rst_illegal",   {31'd0, illegal},   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Table: one instruction per cycle with out_ready=1 (head replaced each edge).
    out_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      in_valid = 1'b1;
      instr    = vecs[i].instr;
      step();
      chk({vecs[i].name, "_valid"}, {31'd0, out_valid}, 32'd1);
      chk({vecs[i].name, "_imm"},   imm,                vecs[i].imm);
      chk({vecs[i].name, "_sel"},   {31'd0, alu2_sel},  {31'd0, vecs[i].sel});
      chk({vecs[i].name, "_ill"},   {31'd0, illegal},   {31'd0, vecs[i].ill});
    end
    in_valid = 1'b0;
    step();
    chk("drain_valid", {31'd0, out_valid}, 32'd0);
    chk("drain_hold_imm", imm, 32'hFFFFFFFC);

    // Backpressure: three pushes, only two fit.
    out_ready = 1'b0;
    got_q.delete();
    push(32'h00100093);
    chk("bp_ready_after1", {31'd0, in_ready}, 32'd1);
    push(32'h00200093);
    chk("bp_ready_after2", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b1;
    instr    = 32'h00300093;
    step();
    chk("bp_stall_imm", imm, 32'd1);
    step();
    chk("bp_stall_imm2", imm, 32'd1);
    chk("bp_stall_ready", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    step();
    chk("bp_head_b", imm, 32'd2);
    chk("bp_ready_reopen", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    chk("bp_head_c", imm, 32'd3);
    step();
    chk("bp_done_valid", {31'd0, out_valid}, 32'd0);
    step();
    chk("bp_count", got_q.size(), 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk("bp_order", (i < got_q.size()) ? got_q[i] : 32'hDEADBEEF, 32'(i + 1));
    end

    // Flush with count=2 and a simultaneous incoming instruction.
    out_ready = 1'b0;
    push(32'h00100093);
    push(32'h00200093);
    in_valid = 1'b1;
    instr    = 32'h00300093;
    flush    = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl2_valid", {31'd0, out_valid}, 32'd0);
    chk("fl2_ready", {31'd0, in_ready},  32'd1);
    out_ready = 1'b1;
    step();
    chk("fl2_dropped", {31'd0, out_valid}, 32'd0);

    // Flush with count=1 while an accept would otherwise land.
    out_ready = 1'b0;
    push(32'h00100093);
    in_valid = 1'b1;
    instr    = 32'h00500093;
    flush    = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl1_valid", {31'd0, out_valid}, 32'd0);
    step();
    chk("fl1_dropped", {31'd0, out_valid}, 32'd0);

    // Asynchronous reset mid-cycle with the buffer full.
    push(32'hFFF00093);
    push(32'h00200093);
    chk("ar_full", {31'd0, in_ready}, 32'd0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", {31'd0, out_valid}, 32'd0);
    chk("ar_ready", {31'd0, in_ready},  32'd1);
    chk("ar_imm",   imm,                32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("ar_post_valid", {31'd0, out_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
